// File: rtl/core_l1i_resp.sv
// Direct-mapped instruction L1 responder with 4-word lines.
// Misses stall fetch while the line is refilled one word per req/ack beat.
module core_l1i_resp #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] l1i_addr_in,
    input  logic        l1i_val_in,
    input  logic        l1i_flush_in,
    output logic [31:0] l1i_data_out,
    output logic        l1i_ack_out,
    output logic        l1i_stall_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_data_in
);
    // state  | meaning
    // IDLE   | lookup; a hit is answered in the following cycle
    // REFILL | line fetched beat 0..3 from memory, fetch stalled
    // RESP   | missed word delivered with ack, stall released
    localparam int IW = $clog2(SETS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags  [SETS];
    logic [31:0]     lines [SETS][LINE_WORDS];

    logic [27:0] base;
    logic [1:0]  word_off;
    logic [1:0]  beat;
    logic        flushed;
    logic [31:0] data_q;
    logic        hit_ack;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [1:0]    req_word;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          lookup_hit;
    logic          start_miss;
    logic          beat_done;
    logic          last_beat;
    logic [31:0]   fill_word;
    logic          unused_addr_bits;

    assign req_tag          = l1i_addr_in[31:4+IW];
    assign req_idx          = l1i_addr_in[3+IW:4];
    assign req_word         = l1i_addr_in[3:2];
    assign fill_idx         = base[IW-1:0];
    assign fill_tag         = base[27:IW];
    assign unused_addr_bits = ^l1i_addr_in[1:0];

    // A flush in the lookup cycle forces the request down the miss path.
    assign lookup_hit = (state == IDLE) && l1i_val_in && !l1i_flush_in
                        && valid[req_idx] && (tags[req_idx] == req_tag);
    assign start_miss = (state == IDLE) && l1i_val_in && !lookup_hit;
    assign beat_done  = (state == REFILL) && mem_ack_in;
    assign last_beat  = beat_done && (beat == 2'd3);

    // The last beat may itself carry the missed word.
    assign fill_word = (word_off == 2'd3) ? mem_data_in : lines[fill_idx][word_off];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_miss) state_nx = REFILL;
            REFILL:  if (last_beat)  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign l1i_stall_out = start_miss || (state == REFILL);
    assign l1i_ack_out   = hit_ack || (state == RESP);
    assign l1i_data_out  = data_q;
    assign mem_req_out   = (state == REFILL);
    assign mem_addr_out  = mem_req_out ? {base, beat, 2'b00} : 32'h0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            valid    <= '0;
            base     <= '0;
            word_off <= '0;
            beat     <= '0;
            flushed  <= 1'b0;
            data_q   <= '0;
            hit_ack  <= 1'b0;
        end else begin
            state   <= state_nx;
            hit_ack <= lookup_hit;
            if (lookup_hit) data_q <= lines[req_idx][req_word];

            if (start_miss) begin
                base     <= l1i_addr_in[31:4];
                word_off <= l1i_addr_in[3:2];
                beat     <= '0;
                flushed  <= 1'b0;
            end else if (l1i_flush_in) begin
                flushed <= 1'b1;
            end

            if (beat_done) beat <= beat + 2'd1;

            // A flush seen during the refill keeps the new line invalid.
            if (last_beat) begin
                data_q          <= fill_word;
                valid[fill_idx] <= !flushed;
            end
            if (l1i_flush_in) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_done) lines[fill_idx][beat] <= mem_data_in;
        if (last_beat) tags[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_core_l1i_resp.sv
// Bench for core_l1i_resp: directed scenarios plus random traffic
// checked against an array-based cache model.
module tb_core_l1i_resp;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] l1i_addr_in = '0;
    logic        l1i_val_in = 1'b0;
    logic        l1i_flush_in = 1'b0;
    logic [31:0] l1i_data_out;
    logic        l1i_ack_out;
    logic        l1i_stall_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_data_in = '0;

    core_l1i_resp dut (
        .clk(clk), .n_rst(n_rst),
        .l1i_addr_in(l1i_addr_in), .l1i_val_in(l1i_val_in), .l1i_flush_in(l1i_flush_in),
        .l1i_data_out(l1i_data_out), .l1i_ack_out(l1i_ack_out), .l1i_stall_out(l1i_stall_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    logic [31:0] mem_salt = 32'h5a5a_0f0f;

    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_data  [64][4];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_salt;
    endfunction

    // Cache model: hit/miss, expected word and ack cycle from the spec rules.
    task automatic model_fetch(input logic [31:0] addr, input int flush_at,
                               output logic [31:0] word, output int exp_ack);
        int idx;
        logic [21:0] tg;
        bit hit;
        idx = int'(addr[9:4]);
        tg  = addr[31:10];
        hit = (flush_at != 0) && m_valid[idx] && (m_tag[idx] == tg);
        exp_ack = hit ? 1 : 1 + 4 * (mem_wait + 1);
        if (!hit) begin
            for (int w = 0; w < 4; w++)
                m_data[idx][w] = mem_val({addr[31:4], 4'h0} + 32'(w * 4));
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
        end
        word = m_data[idx][addr[3:2]];
        if (flush_at >= 0 && flush_at <= exp_ack) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            if (!hit && flush_at == 0) m_valid[idx] = 1'b1;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Memory responder: acks after mem_wait idle cycles, called just after each edge.
    task automatic drive_mem();
        if (mem_req_out) begin
            if (wait_cnt >= mem_wait) begin
                mem_ack_in  = 1'b1;
                mem_data_in = mem_val(mem_addr_out);
                wait_cnt    = 0;
            end else begin
                mem_ack_in  = 1'b0;
                mem_data_in = $urandom;
                wait_cnt++;
            end
        end else begin
            mem_ack_in = 1'b0;
            wait_cnt   = 0;
        end
    endtask

    task automatic idle(input int n, input bit flush);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            l1i_val_in   = 1'b0;
            l1i_flush_in = flush;
            l1i_addr_in  = $urandom;
            drive_mem();
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int flush_at,
                            output logic [31:0] got, output int ack_at, output int stalls,
                            output int beats, output bit addr_ok, output bit overlap);
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        ack_at = -1; stalls = 0; beats = 0; addr_ok = 1'b1; overlap = 1'b0; got = '0;
        for (int k = 0; k < 80 && ack_at < 0; k++) begin
            @(posedge clk); #1;
            l1i_val_in   = (k == 0);
            l1i_addr_in  = (k == 0) ? addr : $urandom;
            l1i_flush_in = (k == flush_at);
            drive_mem();
            if (mem_req_out && mem_addr_out !== base + 32'(beats * 4)) addr_ok = 1'b0;
            if (mem_ack_in) beats++;
            @(negedge clk);
            if (l1i_stall_out) stalls++;
            if (l1i_ack_out && l1i_stall_out) overlap = 1'b1;
            if (l1i_ack_out) begin
                ack_at = k;
                got    = l1i_data_out;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        int ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (l1i_ack_out !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", l1i_ack_out); end
        total++; if (l1i_stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", l1i_stall_out); end
        total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_out); end
        total++; if (l1i_data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", l1i_data_out); end
        @(negedge clk) n_rst = 1'b1;
        mem_wait = 0;
        @(posedge clk); #1;
        l1i_addr_in = 32'h0000_0208; l1i_val_in = 1'b1; drive_mem();
        @(posedge clk); #1;
        l1i_val_in = 1'b0; drive_mem();
        @(posedge clk); #1; drive_mem();
        @(posedge clk); #1; drive_mem();
        @(negedge clk);
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0000_0208) begin
            bad++; $display("FAIL beat2_addr: got req=%b addr=%h want req=1 addr=00000208", mem_req_out, mem_addr_out);
        end
        n_rst = 1'b0;
        @(posedge clk); #1;
        mem_ack_in = 1'b0;
        total++; if ({l1i_ack_out, l1i_stall_out, mem_req_out} !== 3'b000) begin
            bad++; $display("FAIL midreset_ctl: got ack/stall/req=%b want 000", {l1i_ack_out, l1i_stall_out, mem_req_out});
        end
        total++; if (mem_addr_out !== 32'h0 || l1i_data_out !== 32'h0) begin
            bad++; $display("FAIL midreset_bus: got addr=%h data=%h want 0/0", mem_addr_out, l1i_data_out);
        end
        @(negedge clk) n_rst = 1'b1;
        model_clear();
        wait_cnt = 0;
        model_fetch(32'h0000_0208, -1, exp, exp_ack);
        do_fetch(32'h0000_0208, -1, got, ack_at, stalls, beats, addr_ok, overlap);
        total++; if (stalls !== 5) begin bad++; $display("FAIL rereq_stall: got %0d cycles want 5", stalls); end
        total++; if (ack_at !== exp_ack || got !== exp) begin
            bad++; $display("FAIL rereq_data: got ack@%0d %h want ack@%0d %h", ack_at, got, exp_ack, exp);
        end
    endtask

    task automatic test_cold_miss();
        logic [31:0] got, exp;
        int ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        mem_wait = 0;
        model_fetch(32'h0000_0108, -1, exp, exp_ack);
        do_fetch(32'h0000_0108, -1, got, ack_at, stalls, beats, addr_ok, overlap);
        total++; if (stalls !== 5) begin bad++; $display("FAIL cold_stall: got %0d want 5", stalls); end
        total++; if (ack_at !== 5) begin bad++; $display("FAIL cold_ack_cycle: got %0d want 5", ack_at); end
        total++; if (beats !== 4 || !addr_ok) begin bad++; $display("FAIL cold_beats: got beats=%0d addr_ok=%0b want 4/1", beats, addr_ok); end
        total++; if (got !== exp) begin bad++; $display("FAIL cold_data: got %h want %h", got, exp); end
        total++; if (overlap) begin bad++; $display("FAIL cold_overlap: got ack with stall want never"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0, e1;
        int a0, a1;
        model_fetch(32'h0000_010C, -1, e0, a0);
        model_fetch(32'h0000_0100, -1, e1, a1);
        @(posedge clk); #1;
        l1i_addr_in = 32'h0000_010C; l1i_val_in = 1'b1; l1i_flush_in = 1'b0; drive_mem();
        @(negedge clk);
        total++; if (l1i_stall_out !== 1'b0) begin bad++; $display("FAIL b2b_stall0: got %b want 0", l1i_stall_out); end
        @(posedge clk); #1;
        l1i_addr_in = 32'h0000_0100; drive_mem();
        @(negedge clk);
        total++; if (l1i_ack_out !== 1'b1 || l1i_data_out !== e0) begin
            bad++; $display("FAIL b2b_first: got ack=%b %h want ack=1 %h", l1i_ack_out, l1i_data_out, e0);
        end
        total++; if (l1i_stall_out !== 1'b0 || mem_req_out !== 1'b0) begin
            bad++; $display("FAIL b2b_quiet: got stall=%b req=%b want 0/0", l1i_stall_out, mem_req_out);
        end
        @(posedge clk); #1;
        l1i_val_in = 1'b0; drive_mem();
        @(negedge clk);
        total++; if (l1i_ack_out !== 1'b1 || l1i_data_out !== e1) begin
            bad++; $display("FAIL b2b_second: got ack=%b %h want ack=1 %h", l1i_ack_out, l1i_data_out, e1);
        end
        @(posedge clk); #1; drive_mem();
        @(negedge clk);
        total++; if (l1i_ack_out !== 1'b0) begin bad++; $display("FAIL b2b_ack_pulse: got %b want 0", l1i_ack_out); end
    endtask

    task automatic test_wait_states();
        logic [31:0] got, exp;
        int ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        mem_wait = 2;
        model_fetch(32'h0000_0A34, -1, exp, exp_ack);
        do_fetch(32'h0000_0A34, -1, got, ack_at, stalls, beats, addr_ok, overlap);
        total++; if (ack_at !== 13) begin bad++; $display("FAIL wait_ack_cycle: got %0d want 13", ack_at); end
        total++; if (stalls !== 13) begin bad++; $display("FAIL wait_stall: got %0d want 13", stalls); end
        total++; if (!addr_ok || beats !== 4) begin bad++; $display("FAIL wait_addr_hold: got ok=%0b beats=%0d want 1/4", addr_ok, beats); end
        total++; if (got !== exp) begin bad++; $display("FAIL wait_data: got %h want %h", got, exp); end
        mem_wait = 0;
    endtask

    task automatic test_conflict_flush();
        logic [31:0] seq_addr [8] = '{32'h100, 32'h500, 32'h100, 32'h500, 32'h0, 32'h500, 32'h500, 32'h500};
        int          seq_fl   [8] = '{-1, -1, -1, -1, -2, -1, 0, -1};
        logic [31:0] got, exp;
        int ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        mem_wait = 0;
        for (int i = 0; i < 8; i++) begin
            if (seq_fl[i] == -2) begin
                idle(1, 1'b1);
                model_clear();
            end else begin
                model_fetch(seq_addr[i], seq_fl[i], exp, exp_ack);
                do_fetch(seq_addr[i], seq_fl[i], got, ack_at, stalls, beats, addr_ok, overlap);
                total++; if (ack_at !== exp_ack || stalls !== (exp_ack == 1 ? 0 : exp_ack)) begin
                    bad++; $display("FAIL conflict_step%0d: got ack@%0d stall=%0d want ack@%0d", i, ack_at, stalls, exp_ack);
                end
                total++; if (got !== exp) begin bad++; $display("FAIL conflict_data%0d: got %h want %h", i, got, exp); end
            end
        end
        idle(1, 1'b0);
    endtask

    task automatic test_flush_refill();
        logic [31:0] got, exp;
        int ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        mem_wait = 0;
        model_fetch(32'h0000_0744, 2, exp, exp_ack);
        do_fetch(32'h0000_0744, 2, got, ack_at, stalls, beats, addr_ok, overlap);
        total++; if (ack_at !== exp_ack || got !== exp) begin
            bad++; $display("FAIL flushrf_deliver: got ack@%0d %h want ack@%0d %h", ack_at, got, exp_ack, exp);
        end
        model_fetch(32'h0000_0744, -1, exp, exp_ack);
        do_fetch(32'h0000_0744, -1, got, ack_at, stalls, beats, addr_ok, overlap);
        total++; if (stalls !== 5 || ack_at !== 5) begin
            bad++; $display("FAIL flushrf_remiss: got stall=%0d ack@%0d want 5/5", stalls, ack_at);
        end
        total++; if (got !== exp) begin bad++; $display("FAIL flushrf_data: got %h want %h", got, exp); end
    endtask

    task automatic test_random();
        logic [5:0]  idx_pool [4] = '{6'h03, 6'h10, 6'h23, 6'h3F};
        logic [21:0] tg_pool  [3];
        logic [31:0] addr, got, exp;
        int fl, ack_at, stalls, beats, exp_ack;
        bit addr_ok, overlap;
        for (int i = 0; i < 3; i++) tg_pool[i] = 22'($urandom);
        for (int n = 0; n < 40; n++) begin
            addr = {tg_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 3)], 4'($urandom)};
            mem_wait = $urandom_range(0, 2);
            fl = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 2)) : -1;
            if ($urandom_range(0, 7) == 0) mem_salt = $urandom;
            model_fetch(addr, fl, exp, exp_ack);
            do_fetch(addr, fl, got, ack_at, stalls, beats, addr_ok, overlap);
            total++; if (ack_at !== exp_ack || stalls !== (exp_ack == 1 ? 0 : exp_ack)) begin
                bad++; $display("FAIL rand%0d_timing: addr=%h got ack@%0d stall=%0d want ack@%0d", n, addr, ack_at, stalls, exp_ack);
            end
            total++; if (got !== exp) begin bad++; $display("FAIL rand%0d_data: addr=%h got %h want %h", n, addr, got, exp); end
            total++; if (!addr_ok || overlap) begin
                bad++; $display("FAIL rand%0d_bus: got addr_ok=%0b overlap=%0b want 1/0", n, addr_ok, overlap);
            end
            idle($urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_wait_states();
        test_conflict_flush();
        test_flush_refill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule
